// File: rtl/snap_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snap_capture_ctrl
// Purpose  : Sequences one ADC snapshot into a BRAM buffer, honouring a signed
//            trigger offset. Macro SNAP_CIRC_EN enables pre-trigger history.
// Revision : 1.0
// ============================================================================
module snap_capture_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int OFFSET_W = 32
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic                ctrl_en,
  input  logic                ctrl_trig_src,
  input  logic                ctrl_we_src,
  input  logic [OFFSET_W-1:0] trig_offset,
  input  logic                trig,
  input  logic                din_valid,
  input  logic [DATA_W-1:0]   din,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_data,
  output logic                bram_we,
  output logic                status_done,
  output logic [ADDR_W-1:0]   status_addr,
  output logic [ADDR_W-1:0]   status_trig_addr
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARMED   = 3'd1;
  localparam logic [2:0] DELAY   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]          state;
  logic                en_d;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W:0]     post_cnt;
  logic [ADDR_W:0]     post_len;
  logic [OFFSET_W-1:0] skip_cnt;
  logic [OFFSET_W-1:0] skip_len;

  logic                arm;
  logic                v;
  logic                t;
  logic                skip_zero;
  logic                pre_write;
  logic                post_write;
  logic                do_write;
  logic                last_write;
  logic [OFFSET_W-1:0] skip_next;
  logic [ADDR_W:0]     post_next;

  assign arm        = ctrl_en & ~en_d;
  assign v          = din_valid | ctrl_we_src;
  assign t          = v & (trig | ctrl_trig_src);
  assign skip_zero  = (skip_len == '0);
  assign skip_next  = (!trig_offset[OFFSET_W-1] && (trig_offset != '0)) ? trig_offset : '0;
  // The trigger sample is itself the first post-trigger write when there is no skip.
  assign post_write = !arm && v && ((state == CAPTURE) || ((state == ARMED) && t && skip_zero));
  assign last_write = post_write && ((post_cnt + (ADDR_W+1)'(1)) == post_len);
  assign do_write   = pre_write | post_write;

`ifdef SNAP_CIRC_EN
  localparam logic [OFFSET_W-1:0] MAX_PRE = {{(OFFSET_W-ADDR_W){1'b0}}, {ADDR_W{1'b1}}};

  logic [ADDR_W-1:0]   pre_len;
  logic [ADDR_W-1:0]   pre_next;
  logic [OFFSET_W-1:0] neg_off;

  assign neg_off   = -trig_offset;
  assign pre_next  = !trig_offset[OFFSET_W-1] ? '0 :
                     (neg_off > MAX_PRE)      ? {ADDR_W{1'b1}} : neg_off[ADDR_W-1:0];
  assign post_next = DEPTH - {1'b0, pre_next};
  assign pre_write = !arm && v && !t && (state == ARMED) && (pre_len != '0);

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      pre_len <= '0;
    end else if (arm) begin
      pre_len <= pre_next;
    end
  end
`else
  assign post_next = DEPTH;
  assign pre_write = 1'b0;
`endif

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state            <= IDLE;
      en_d             <= 1'b0;
      wr_ptr           <= '0;
      post_cnt         <= '0;
      post_len         <= '0;
      skip_cnt         <= '0;
      skip_len         <= '0;
      bram_addr        <= '0;
      bram_data        <= '0;
      bram_we          <= 1'b0;
      status_done      <= 1'b0;
      status_addr      <= '0;
      status_trig_addr <= '0;
    end else begin
      en_d    <= ctrl_en;
      bram_we <= do_write;
      if (do_write) begin
        bram_data <= din;
        bram_addr <= wr_ptr;
        wr_ptr    <= wr_ptr + ADDR_W'(1);
      end
      if (post_write) begin
        post_cnt <= post_cnt + (ADDR_W+1)'(1);
      end
      if (arm) begin
        state       <= ARMED;
        wr_ptr      <= '0;
        bram_addr   <= '0;
        post_cnt    <= '0;
        skip_cnt    <= '0;
        skip_len    <= skip_next;
        post_len    <= post_next;
        status_done <= 1'b0;
      end else begin
        case (state)
          ARMED: begin
            if (t) begin
              status_trig_addr <= wr_ptr;
              if (skip_zero) begin
                state <= CAPTURE;
              end else begin
                skip_cnt <= OFFSET_W'(1);
                state    <= (skip_len == OFFSET_W'(1)) ? CAPTURE : DELAY;
              end
            end
          end
          DELAY: begin
            if (v) begin
              skip_cnt <= skip_cnt + OFFSET_W'(1);
              if ((skip_cnt + OFFSET_W'(1)) == skip_len) begin
                state <= CAPTURE;
              end
            end
          end
          default: ;
        endcase
        if (last_write) begin
          state       <= DONE;
          status_done <= 1'b1;
          status_addr <= wr_ptr;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snap_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snap_capture_ctrl
// Purpose  : Scoreboard bench for snap_capture_ctrl (ADDR_W=4), honours SNAP_CIRC_EN.
// Revision : 1.0
// ============================================================================
module tb_snap_capture_ctrl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int OW = 32;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctrl_en;
  logic          ctrl_trig_src;
  logic          ctrl_we_src;
  logic [OW-1:0] trig_offset;
  logic          trig;
  logic          din_valid;
  logic [DW-1:0] din;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data;
  logic          bram_we;
  logic          status_done;
  logic [AW-1:0] status_addr;
  logic [AW-1:0] status_trig_addr;

  always #5 clk = ~clk;

  snap_capture_ctrl #(.ADDR_W(AW), .DATA_W(DW), .OFFSET_W(OW)) dut (
    .user_clk        (clk),
    .user_rst        (rst),
    .ctrl_en         (ctrl_en),
    .ctrl_trig_src   (ctrl_trig_src),
    .ctrl_we_src     (ctrl_we_src),
    .trig_offset     (trig_offset),
    .trig            (trig),
    .din_valid       (din_valid),
    .din             (din),
    .bram_addr       (bram_addr),
    .bram_data       (bram_data),
    .bram_we         (bram_we),
    .status_done     (status_done),
    .status_addr     (status_addr),
    .status_trig_addr(status_trig_addr)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;
  bit mon_on = 1'b0;

  // Reference model state: counts valid samples since arm and locates writes arithmetically.
  bit            m_en_prev = 1'b0;
  bit            m_armed   = 1'b0;
  bit            exp_done  = 1'b0;
  int            m_P, m_S, m_nv, m_tidx, m_base;
  logic [AW-1:0] exp_trig  = '0;
  logic [AW-1:0] exp_saddr = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (mon_on) begin
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("bram_we", bram_we, 1'b1);
          if (bram_we) begin
            chk("bram_addr", bram_addr, mon_e[AW+DW-1:DW]);
            chk("bram_data", bram_data, mon_e[DW-1:0]);
          end
        end else begin
          chk("no_write", bram_we, 1'b0);
        end
        chk("status_done", status_done, exp_done);
      end
    end
  end

  task automatic step(input bit en, input bit tsrc, input bit wsrc, input bit tg,
                      input bit dv, input logic [DW-1:0] d, input int off);
    bit v, t;
    int i, k;
    ctrl_en = en; ctrl_trig_src = tsrc; ctrl_we_src = wsrc;
    trig = tg; din_valid = dv; din = d; trig_offset = off;
    v = wsrc | dv;
    t = v && (tg || tsrc);
    if (en && !m_en_prev) begin
      m_armed = 1'b1; exp_done = 1'b0; m_nv = 0; m_tidx = -1; m_base = 0;
      m_S = (off > 0) ? off : 0;
`ifdef SNAP_CIRC_EN
      m_P = (off < 0) ? ((-off > D-1) ? D-1 : -off) : 0;
`else
      m_P = 0;
`endif
    end else if (m_armed && v) begin
      i = m_nv;
      m_nv++;
      if (m_tidx < 0) begin
        if (t) begin
          m_tidx   = i;
          m_base   = (m_P > 0) ? (i % D) : 0;
          exp_trig = AW'(m_base);
        end else if (m_P > 0) begin
          exp_q.push_back({AW'(i % D), d});
        end
      end
      if (m_tidx >= 0) begin
        k = i - m_tidx - m_S;
        if (k >= 0 && k < D - m_P) begin
          exp_q.push_back({AW'((m_base + k) % D), d});
          if (k == D - m_P - 1) begin
            exp_done  = 1'b1;
            exp_saddr = AW'((m_base + k) % D);
            m_armed   = 1'b0;
          end
        end
      end
    end
    m_en_prev = en;
    @(posedge clk); #2;
  endtask

  // trig_at < 0 selects a random trigger; rearm_cyc < 0 disables the mid-run re-arm.
  task automatic run_capture(input int off, input bit wsrc, input bit tsrc, input int trig_at,
                             input int dv_mode, input int rearm_cyc, input bit rnd);
    int cnt, cyc;
    bit en, tg, dv;
    logic [DW-1:0] d;
    step(1'b0, 1'b0, wsrc, 1'b0, 1'b0, '0, int'($urandom));
    step(1'b1, tsrc, wsrc, 1'b1, 1'b1, 32'hA5A5_5A5A, off);
    cnt = 0;
    cyc = 0;
    while (!exp_done && cyc < 600) begin
      en = (cyc != rearm_cyc);
      tg = (trig_at < 0) ? ($urandom_range(0, 7) == 0) : (cnt >= trig_at);
      case (dv_mode)
        0:       dv = 1'b1;
        1:       dv = ((cnt % 3) == 0);
        default: dv = 1'(($urandom_range(0, 1)));
      endcase
      d = rnd ? $urandom : DW'(cnt);
      step(en, tsrc, wsrc, tg, dv, d, (cyc == rearm_cyc + 1) ? off : int'($urandom));
      cnt++;
      cyc++;
    end
    if (!exp_done) begin
      n_chk++;
      $display("FAIL capture_timeout: got not done expected done within 600 cycles (off=%0d)", off);
    end
    repeat (3) step(1'b1, tsrc, wsrc, 1'b1, 1'b1, $urandom, int'($urandom));
    chk("status_done_end", status_done, 1'b1);
    chk("status_addr", status_addr, exp_saddr);
    chk("status_trig_addr", status_trig_addr, exp_trig);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int offr;
    rst = 1'b1; ctrl_en = 1'b0; ctrl_trig_src = 1'b0; ctrl_we_src = 1'b0;
    trig_offset = '0; trig = 1'b0; din_valid = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_bram_we", bram_we, 1'b0);
    chk("rst_bram_addr", bram_addr, '0);
    chk("rst_bram_data", bram_data, '0);
    chk("rst_status_done", status_done, 1'b0);
    chk("rst_status_addr", status_addr, '0);
    chk("rst_status_trig_addr", status_trig_addr, '0);
    #1 mon_on = 1'b1;
    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, $urandom, -3);

    run_capture(0, 1'b1, 1'b0, 5, 0, -1, 1'b0);
    chk("t2_status_addr", status_addr, 4'd15);
    chk("t2_trig_addr", status_trig_addr, 4'd0);
    run_capture(3, 1'b1, 1'b0, 5, 0, -1, 1'b0);
    chk("t3_trig_addr", status_trig_addr, 4'd0);
    run_capture(-4, 1'b1, 1'b0, 20, 0, -1, 1'b0);
`ifdef SNAP_CIRC_EN
    chk("t4_trig_addr", status_trig_addr, 4'd4);
`endif
    chk("t4_status_addr", status_addr, 4'd15);
    run_capture(0, 1'b0, 1'b0, 5, 1, -1, 1'b0);
    run_capture(-3, 1'b1, 1'b0, 3, 0, 11, 1'b0);
    run_capture(2, 1'b0, 1'b1, 0, 2, -1, 1'b1);
    run_capture(-30, 1'b1, 1'b0, 2, 0, -1, 1'b1);
    run_capture(1, 1'b1, 1'b0, 4, 0, -1, 1'b1);

    repeat (10) begin
      offr = int'($urandom_range(0, 40)) - 20;
      run_capture(offr, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), -1,
                  int'($urandom_range(0, 2)),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 25)) : -1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snap_capture_ctrl.md
Name: snap_capture_ctrl

Overview:
Sequences one ADC snapshot capture into a BRAM-backed snapshot buffer (adcsnap0 and siblings). Armed by software through a control register. Honours the trigger-offset register: a positive offset delays the capture after the trigger; a negative offset keeps pre-trigger history. Sits in the user_clk fabric domain between the software registers, the ADC sample stream and the snapshot BRAM write port, and reports completion and addresses back through status registers.

Parameters:
ADDR_W, 10, BRAM address width; depth D = 2^ADDR_W samples
DATA_W, 32, sample/BRAM data width
OFFSET_W, 32, width of the signed trig_offset register

Ports:
user_clk  in  1  fabric clock; all logic on rising edge
user_rst  in  1  synchronous, active-high reset
ctrl_en  in  1  arm request; its rising edge arms or restarts
ctrl_trig_src  in  1  0 = external trig input; 1 = trigger immediately
ctrl_we_src  in  1  0 = sample valid is din_valid; 1 = every cycle valid
trig_offset  in  OFFSET_W  signed offset in valid samples, latched at arm
trig  in  1  external trigger, qualified by sample valid
din_valid  in  1  sample strobe
din  in  DATA_W  ADC sample
bram_addr  out  ADDR_W  BRAM write address
bram_data  out  DATA_W  BRAM write data
bram_we  out  1  BRAM write enable
status_done  out  1  capture complete
status_addr  out  ADDR_W  address of last BRAM write
status_trig_addr  out  ADDR_W  address holding trigger sample (0 if offset>0)

Behaviour:
- Reset: state IDLE; all outputs 0; edge detector primed with 0.
- Sample valid: v = din_valid, or 1 when ctrl_we_src=1. Qualified trigger: t = v & (trig | ctrl_trig_src).
- Latency: sample accepted at cycle k drives bram_we/bram_data/bram_addr at k+1. bram_addr steps only after a write, mod D.
- Arm: a rising edge of ctrl_en in any state does all of the following, then enters ARMED:
  - latch trig_offset as O;
  - clear the address, the counters and status_done.
  - Level changes otherwise ignored; falling edge mid-capture has no effect.
- Pre-trigger count: P = min(-O, D-1) when O<0 (SNAP_CIRC_EN only), else 0. Skip count: S = O when O>0, else 0.
- ARMED: if P>0, every valid sample is written circularly. On t:
  - status_trig_addr <= current write address.
  - If S=0: the trigger sample is written as post-trigger sample 1. Go CAPTURE.
  - If S>0: the trigger sample counts as skip 1. Go DELAY; if S=1, go straight to CAPTURE.
- DELAY: count valid samples, no writes. After S skipped samples, the next valid sample is written at address 0. Go CAPTURE.
- CAPTURE: write each valid sample. Stop after D-P post-trigger writes in total, including the trigger sample when S=0. Go DONE.
- DONE: bram_we=0; status_done=1; status_addr = address of final write. Hold until reset or re-arm.
- Boundaries:
  - trig while in DELAY/CAPTURE/DONE is ignored.
  - Trigger before the pre-trigger history fills still writes D-P post samples; stale entries are allowed.
  - Simultaneous arm edge and trig: the arm wins; the trigger is evaluated from the next cycle.
  - O magnitude beyond 2^31-1 is not supported.

Optional Feature:
SNAP_CIRC_EN
- Defined: negative offsets give P pre-trigger samples via circular writes in ARMED.
- Undefined: P is forced to 0, no writes in ARMED, and negative O behaves as O=0. The circular-fill logic is removed.

Test Plan:
1. Hold user_rst 3 cycles, then release → every output 0, no bram_we until an arm edge.
2. ADDR_W=4, O=0, ctrl_we_src=1, din=counter, trig at din=5 → 16 writes: addr 0..15, data 5..20; status_done=1; status_addr=15; status_trig_addr=0.
3. ADDR_W=4, O=+3, trig at din=5 → first write addr 0 = 8, last = 23; status_trig_addr=0.
4. SNAP_CIRC_EN, ADDR_W=4, O=-4, arm, trig at din=20 → din 19 at addr 3, din 20 at addr 4, 12 post writes; status_trig_addr=4; status_addr=15; addrs 0..3 hold 16..19.
5. din_valid one cycle in three, O=0 → writes only on valid samples, addr advances once per valid, done after 16 valid samples.
6. Re-arm edge mid-CAPTURE (addr=7) → next write at addr 0; status_done stays 0 until the new capture completes; the new trig sets a new status_trig_addr.
